// File: rtl/ahblite_pkg.sv
// Shared AHB-Lite encodings and the SRAM responder state type.
// Optional build macro used by the SRAM responder: AHBL_SRAM_WRITE_PROTECT_EN.
package ahblite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE     = 3'b000;
  localparam logic [2:0] HSIZE_HALFWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD     = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_LAST,
    ST_ERR1,
    ST_ERR2
  } sram_state_e;

endpackage

// File: rtl/ahblite_sram_slave_if.sv
// AHB-Lite responder-side bus bundle; master drives requests, slave returns response.
interface ahblite_sram_slave_if #(
  parameter int unsigned HADDR_WIDTH = 32,
  parameter int unsigned HDATA_WIDTH = 32
);
  logic                   HSEL_i;
  logic [1:0]             HTRANS_i;
  logic [2:0]             HBURST_i;
  logic [2:0]             HSIZE_i;
  logic                   HWRITE_i;
  logic [HADDR_WIDTH-1:0] HADDR_i;
  logic [HDATA_WIDTH-1:0] HWDATA_i;
  logic [6:0]             HPROT_i;
  logic                   HMASTLOCK_i;
  logic                   HREADY_i;
  logic                   HREADYOUT_o;
  logic [HDATA_WIDTH-1:0] HRDATA_o;
  logic                   HRESP_o;

  modport slave (
    input  HSEL_i, HTRANS_i, HBURST_i, HSIZE_i, HWRITE_i, HADDR_i, HWDATA_i,
    input  HPROT_i, HMASTLOCK_i, HREADY_i,
    output HREADYOUT_o, HRDATA_o, HRESP_o
  );

  modport master (
    output HSEL_i, HTRANS_i, HBURST_i, HSIZE_i, HWRITE_i, HADDR_i, HWDATA_i,
    output HPROT_i, HMASTLOCK_i, HREADY_i,
    input  HREADYOUT_o, HRDATA_o, HRESP_o
  );
endinterface

// File: rtl/ahblite_slv_wstrb_gen.sv
// Byte-lane write strobe from transfer size and the low address bits.
module ahblite_slv_wstrb_gen
  import ahblite_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] wstrb_c
);

  always_comb begin
    wstrb_c = 4'b0000;
    case (size)
      HSIZE_BYTE:     wstrb_c = 4'b0001 << addr_lo;
      HSIZE_HALFWORD: wstrb_c = 4'b0011 << addr_lo;
      HSIZE_WORD:     wstrb_c = 4'b1111;
      default:        wstrb_c = 4'b0000;
    endcase
  end

endmodule

// File: rtl/ahblite_sram_slave.sv
// AHB-Lite SRAM responder: configurable wait states, byte-strobed writes, two-cycle ERROR.
// Optional build macro: AHBL_SRAM_WRITE_PROTECT_EN (unprivileged writes at/above PROT_BASE error).
module ahblite_sram_slave
  import ahblite_pkg::*;
#(
  parameter int unsigned HADDR_WIDTH = 32,
  parameter int unsigned HDATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned PROT_BASE   = 'h80
) (
  input logic                 HCLK,
  input logic                 HRESET,
  ahblite_sram_slave_if.slave bus
);

  localparam int unsigned            IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [HADDR_WIDTH-1:0] MEM_BYTES = HADDR_WIDTH'(MEM_DEPTH * 4);
  localparam logic [3:0]             WS_LAST   = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  logic [HDATA_WIDTH-1:0] mem [MEM_DEPTH];

  sram_state_e            state;
  logic [3:0]             wait_cnt;
  logic [HADDR_WIDTH-1:0] a_addr;
  logic [2:0]             a_size;
  logic                   a_write;
  logic [6:0]             a_prot;
  logic                   hreadyout;
  logic                   hresp;
  logic [HDATA_WIDTH-1:0] hrdata;

  logic                   accept_c;
  logic                   misalign_c;
  logic                   protect_c;
  logic                   illegal_c;
  logic                   wr_en_c;
  logic                   fwd_c;
  logic [IDX_W-1:0]       wr_idx_c;
  logic [IDX_W-1:0]       rd_idx_c;
  logic [3:0]             wstrb_c;
  logic [HDATA_WIDTH-1:0] rd_word_c;
  logic                   unused_c;

  assign bus.HREADYOUT_o = hreadyout;
  assign bus.HRESP_o     = hresp;
  assign bus.HRDATA_o    = hrdata;

  assign accept_c = bus.HSEL_i & bus.HREADY_i & bus.HTRANS_i[1];

  always_comb begin
    misalign_c = 1'b0;
    case (bus.HSIZE_i)
      HSIZE_HALFWORD: misalign_c = bus.HADDR_i[0];
      HSIZE_WORD:     misalign_c = |bus.HADDR_i[1:0];
      default:        misalign_c = 1'b0;
    endcase
  end

`ifdef AHBL_SRAM_WRITE_PROTECT_EN
  assign protect_c = bus.HWRITE_i & ~bus.HPROT_i[1] & (bus.HADDR_i >= HADDR_WIDTH'(PROT_BASE));
`else
  assign protect_c = 1'b0;
`endif

  assign illegal_c = (bus.HADDR_i >= MEM_BYTES) | (bus.HSIZE_i > HSIZE_WORD) | misalign_c | protect_c;

  ahblite_slv_wstrb_gen u_wstrb (
    .size    (a_size),
    .addr_lo (a_addr[1:0]),
    .wstrb_c (wstrb_c)
  );

  // The write commits on the edge that ends LAST; a read loaded on that same edge sees it.
  assign wr_en_c  = (state == ST_LAST) & a_write & ~HRESET;
  assign wr_idx_c = a_addr[IDX_W+1:2];
  assign rd_idx_c = (state == ST_WAIT) ? a_addr[IDX_W+1:2] : bus.HADDR_i[IDX_W+1:2];
  assign fwd_c    = wr_en_c & (wr_idx_c == rd_idx_c);

  always_comb begin
    rd_word_c = mem[rd_idx_c];
    for (int b = 0; b < 4; b++) begin
      if (fwd_c && wstrb_c[b]) rd_word_c[8*b +: 8] = bus.HWDATA_i[8*b +: 8];
    end
  end

  always_ff @(posedge HCLK) begin
    if (wr_en_c) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_c[b]) mem[wr_idx_c][8*b +: 8] <= bus.HWDATA_i[8*b +: 8];
      end
    end
  end

  // Transfer FSM; outputs are registered to match the state being entered.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= ST_IDLE;
      wait_cnt  <= 4'd0;
      a_addr    <= '0;
      a_size    <= 3'd0;
      a_write   <= 1'b0;
      a_prot    <= 7'd0;
      hreadyout <= 1'b1;
      hresp     <= HRESP_OKAY;
      hrdata    <= '0;
    end else begin
      hreadyout <= 1'b1;
      hresp     <= HRESP_OKAY;
      hrdata    <= '0;
      case (state)
        ST_WAIT: begin
          if (wait_cnt == WS_LAST) begin
            state    <= ST_LAST;
            wait_cnt <= 4'd0;
            if (!a_write) hrdata <= rd_word_c;
          end else begin
            wait_cnt  <= wait_cnt + 4'd1;
            hreadyout <= 1'b0;
          end
        end
        ST_ERR1: begin
          state <= ST_ERR2;
          hresp <= HRESP_ERROR;
        end
        default: begin
          // IDLE, LAST and ERR2 all end a data phase and may take a new address phase
          state <= ST_IDLE;
          if (accept_c) begin
            a_addr  <= bus.HADDR_i;
            a_size  <= bus.HSIZE_i;
            a_write <= bus.HWRITE_i;
            a_prot  <= bus.HPROT_i;
            if (illegal_c) begin
              state     <= ST_ERR1;
              hreadyout <= 1'b0;
              hresp     <= HRESP_ERROR;
            end else if (WAIT_STATES != 0) begin
              state     <= ST_WAIT;
              wait_cnt  <= 4'd0;
              hreadyout <= 1'b0;
            end else begin
              state <= ST_LAST;
              if (!bus.HWRITE_i) hrdata <= rd_word_c;
            end
          end
        end
      endcase
    end
  end

  assign unused_c = ^{a_addr, a_prot, bus.HBURST_i, bus.HMASTLOCK_i};

endmodule

// File: tb/tb_ahblite_sram_slave.sv
// Self-checking bench for ahblite_sram_slave: zero-wait and two-wait instances, table plus scoreboard.
module tb_ahblite_sram_slave;
  import ahblite_pkg::*;

  localparam int unsigned WS_A = 0;
  localparam int unsigned WS_B = 2;
  localparam int          NV   = 29;
  localparam int          NA   = 25;

  typedef struct {
    logic        write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [6:0]  prot;
    logic        exp_resp;
    logic [31:0] exp_rdata;
    int          exp_waits;
  } vec_t;

  typedef struct {
    logic        resp;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        dsel;
  logic        hsel;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hwrite;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [6:0]  hprot;
  logic        hready_lo;

  int   n_checks;
  int   n_pass;
  vec_t vt [NV];
  exp_t sb [$];

  ahblite_sram_slave_if #(.HADDR_WIDTH(32), .HDATA_WIDTH(32)) if_a ();
  ahblite_sram_slave_if #(.HADDR_WIDTH(32), .HDATA_WIDTH(32)) if_b ();

  assign if_a.HSEL_i      = hsel & ~dsel;
  assign if_a.HTRANS_i    = htrans;
  assign if_a.HBURST_i    = HBURST_SINGLE;
  assign if_a.HSIZE_i     = hsize;
  assign if_a.HWRITE_i    = hwrite;
  assign if_a.HADDR_i     = haddr;
  assign if_a.HWDATA_i    = hwdata;
  assign if_a.HPROT_i     = hprot;
  assign if_a.HMASTLOCK_i = 1'b0;
  assign if_a.HREADY_i    = if_a.HREADYOUT_o & ~hready_lo;

  assign if_b.HSEL_i      = hsel & dsel;
  assign if_b.HTRANS_i    = htrans;
  assign if_b.HBURST_i    = HBURST_INCR;
  assign if_b.HSIZE_i     = hsize;
  assign if_b.HWRITE_i    = hwrite;
  assign if_b.HADDR_i     = haddr;
  assign if_b.HWDATA_i    = hwdata;
  assign if_b.HPROT_i     = hprot;
  assign if_b.HMASTLOCK_i = 1'b0;
  assign if_b.HREADY_i    = if_b.HREADYOUT_o & ~hready_lo;

  ahblite_sram_slave #(.WAIT_STATES(WS_A)) u_dut_a (.HCLK(clk), .HRESET(rst), .bus(if_a.slave));
  ahblite_sram_slave #(.WAIT_STATES(WS_B)) u_dut_b (.HCLK(clk), .HRESET(rst), .bus(if_b.slave));

  logic        rdy;
  logic        resp;
  logic [31:0] rdata;
  assign rdy   = dsel ? if_b.HREADYOUT_o : if_a.HREADYOUT_o;
  assign resp  = dsel ? if_b.HRESP_o     : if_a.HRESP_o;
  assign rdata = dsel ? if_b.HRDATA_o    : if_a.HRDATA_o;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 'h%08h, expected 'h%08h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic w, input logic [2:0] sz, input logic [31:0] a,
                              input logic [31:0] wd, input logic [6:0] p, input logic er,
                              input logic [31:0] rd, input int ws);
    vec_t v;
    v.write     = w;
    v.size      = sz;
    v.addr      = a;
    v.wdata     = wd;
    v.prot      = p;
    v.exp_resp  = er;
    v.exp_rdata = rd;
    v.exp_waits = er ? 1 : ws;
    return v;
  endfunction

  // Issue vt[first..last] back-to-back, checking each data phase against the scoreboard.
  task automatic run_seq(input int first, input int last);
    int   ai;
    int   di;
    int   waits;
    int   guard;
    logic issued;
    logic rdy_s;
    exp_t e;
    ai = first; di = -1; waits = 0; guard = 0;
    while ((ai <= last || di >= 0) && guard < 400) begin
      guard++;
      issued = (ai <= last);
      if (issued) begin
        hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = vt[ai].write;
        hsize = vt[ai].size; haddr = vt[ai].addr; hprot = vt[ai].prot;
      end else begin
        hsel = 1'b0; htrans = HTRANS_IDLE;
      end
      hwdata = (di >= 0) ? vt[di].wdata : 32'h0;
      @(negedge clk);
      rdy_s = rdy;
      if (di >= 0) begin
        if (!rdy) begin
          waits++;
          check($sformatf("v%0d stall hresp", di), 32'(resp), 32'(sb[0].resp));
        end else begin
          e = sb.pop_front();
          check($sformatf("v%0d hresp", di), 32'(resp), 32'(e.resp));
          check($sformatf("v%0d hrdata", di), rdata, e.rdata);
          check($sformatf("v%0d wait cycles", di), 32'(waits), 32'(e.waits));
          di = -1;
        end
      end
      @(posedge clk);
      #1;
      if (rdy_s && issued) begin
        e.resp  = vt[ai].exp_resp;
        e.rdata = vt[ai].exp_rdata;
        e.waits = vt[ai].exp_waits;
        sb.push_back(e);
        di = ai; ai++; waits = 0;
      end
    end
    hsel = 1'b0; htrans = HTRANS_IDLE;
    if (guard >= 400) check("run_seq timeout", 32'd1, 32'd0);
  endtask

  logic [1:0] na_trans [4];
  logic       na_sel   [4];
  logic       na_rlo   [4];

  initial begin
    n_checks = 0; n_pass = 0;
    rst = 1'b1; dsel = 1'b0; hsel = 1'b0; htrans = HTRANS_IDLE; hsize = HSIZE_WORD;
    hwrite = 1'b0; haddr = 32'h0; hwdata = 32'h0; hprot = 7'd0; hready_lo = 1'b0;

    vt[0]  = mk(1, HSIZE_WORD,     32'h010, 32'hDEADBEEF, 7'h02, 0, 32'h0, WS_A);
    vt[1]  = mk(0, HSIZE_WORD,     32'h010, 32'h0,        7'h02, 0, 32'hDEADBEEF, WS_A);
    vt[2]  = mk(1, HSIZE_BYTE,     32'h020, 32'h00000011, 7'h02, 0, 32'h0, WS_A);
    vt[3]  = mk(1, HSIZE_BYTE,     32'h021, 32'h00002200, 7'h02, 0, 32'h0, WS_A);
    vt[4]  = mk(1, HSIZE_HALFWORD, 32'h022, 32'h44330000, 7'h02, 0, 32'h0, WS_A);
    vt[5]  = mk(0, HSIZE_WORD,     32'h020, 32'h0,        7'h02, 0, 32'h44332211, WS_A);
    vt[6]  = mk(1, HSIZE_WORD,     32'h000, 32'h01234567, 7'h02, 0, 32'h0, WS_A);
    vt[7]  = mk(0, HSIZE_WORD,     32'h002, 32'h0,        7'h02, 1, 32'h0, WS_A);
    vt[8]  = mk(1, HSIZE_WORD,     32'h400, 32'hBADBAD00, 7'h02, 1, 32'h0, WS_A);
    vt[9]  = mk(0, HSIZE_WORD,     32'h000, 32'h0,        7'h02, 0, 32'h01234567, WS_A);
    vt[10] = mk(1, HSIZE_HALFWORD, 32'h021, 32'hFFFFFFFF, 7'h02, 1, 32'h0, WS_A);
    vt[11] = mk(0, 3'b011,         32'h020, 32'h0,        7'h02, 1, 32'h0, WS_A);
    vt[12] = mk(0, HSIZE_BYTE,     32'h013, 32'h0,        7'h02, 0, 32'hDEADBEEF, WS_A);
    vt[13] = mk(0, HSIZE_HALFWORD, 32'h022, 32'h0,        7'h02, 0, 32'h44332211, WS_A);
    vt[14] = mk(1, HSIZE_WORD,     32'h080, 32'h11112222, 7'h02, 0, 32'h0, WS_A);
`ifdef AHBL_SRAM_WRITE_PROTECT_EN
    vt[15] = mk(1, HSIZE_WORD,     32'h080, 32'hCAFEF00D, 7'h00, 1, 32'h0, WS_A);
    vt[16] = mk(0, HSIZE_WORD,     32'h080, 32'h0,        7'h00, 0, 32'h11112222, WS_A);
`else
    vt[15] = mk(1, HSIZE_WORD,     32'h080, 32'hCAFEF00D, 7'h00, 0, 32'h0, WS_A);
    vt[16] = mk(0, HSIZE_WORD,     32'h080, 32'h0,        7'h00, 0, 32'hCAFEF00D, WS_A);
`endif
    vt[17] = mk(1, HSIZE_WORD,     32'h080, 32'hCAFEF00D, 7'h02, 0, 32'h0, WS_A);
    vt[18] = mk(0, HSIZE_WORD,     32'h080, 32'h0,        7'h00, 0, 32'hCAFEF00D, WS_A);
    vt[19] = mk(1, HSIZE_WORD,     32'h07C, 32'h0000007C, 7'h00, 0, 32'h0, WS_A);
    vt[20] = mk(0, HSIZE_WORD,     32'h07C, 32'h0,        7'h00, 0, 32'h0000007C, WS_A);
    vt[21] = mk(1, HSIZE_WORD,     32'h3FC, 32'hA5A5A5A5, 7'h02, 0, 32'h0, WS_A);
    vt[22] = mk(0, HSIZE_WORD,     32'h3FC, 32'h0,        7'h02, 0, 32'hA5A5A5A5, WS_A);
    vt[23] = mk(1, HSIZE_WORD,     32'h012, 32'hFFFFFFFF, 7'h02, 1, 32'h0, WS_A);
    vt[24] = mk(0, HSIZE_WORD,     32'h010, 32'h0,        7'h02, 0, 32'hDEADBEEF, WS_A);
    vt[25] = mk(1, HSIZE_WORD,     32'h004, 32'h5A5A0004, 7'h02, 0, 32'h0, WS_B);
    vt[26] = mk(0, HSIZE_WORD,     32'h004, 32'h0,        7'h02, 0, 32'h5A5A0004, WS_B);
    vt[27] = mk(0, HSIZE_WORD,     32'h006, 32'h0,        7'h02, 1, 32'h0, WS_B);
    vt[28] = mk(0, HSIZE_WORD,     32'h004, 32'h0,        7'h02, 0, 32'h5A5A0004, WS_B);

    na_sel[0] = 1'b1; na_trans[0] = HTRANS_NONSEQ; na_rlo[0] = 1'b1;
    na_sel[1] = 1'b0; na_trans[1] = HTRANS_NONSEQ; na_rlo[1] = 1'b0;
    na_sel[2] = 1'b1; na_trans[2] = HTRANS_BUSY;   na_rlo[2] = 1'b0;
    na_sel[3] = 1'b1; na_trans[3] = HTRANS_IDLE;   na_rlo[3] = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset hreadyout a", 32'(if_a.HREADYOUT_o), 32'd1);
    check("reset hresp a",     32'(if_a.HRESP_o),     32'd0);
    check("reset hrdata a",    if_a.HRDATA_o,         32'd0);
    check("reset hreadyout b", 32'(if_b.HREADYOUT_o), 32'd1);
    check("reset hresp b",     32'(if_b.HRESP_o),     32'd0);
    check("reset hrdata b",    if_b.HRDATA_o,         32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    dsel = 1'b0;
    run_seq(0, NA - 1);

    // Cycles that must not start a transfer: HREADY low, deselected, BUSY, IDLE
    for (int k = 0; k < 4; k++) begin
      hsel = na_sel[k]; htrans = na_trans[k]; hready_lo = na_rlo[k];
      hwrite = 1'b0; hsize = HSIZE_WORD; haddr = 32'h010;
      @(posedge clk);
      #1;
      hsel = 1'b0; htrans = HTRANS_IDLE; hready_lo = 1'b0;
      @(negedge clk);
      check($sformatf("no-accept %0d hreadyout", k), 32'(rdy), 32'd1);
      check($sformatf("no-accept %0d hresp", k),     32'(resp), 32'd0);
      check($sformatf("no-accept %0d hrdata", k),    rdata, 32'd0);
      @(posedge clk);
      #1;
    end

    dsel = 1'b1;
    run_seq(NA, 27);

    // Reset while a write is stalled in WAIT: write is dropped
    hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b1; hsize = HSIZE_WORD;
    haddr = 32'h004; hprot = 7'h02;
    @(posedge clk);
    #1;
    hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'hFFFF0000;
    @(negedge clk);
    check("pre-reset stall hreadyout", 32'(rdy), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post-reset hreadyout", 32'(rdy), 32'd1);
    check("post-reset hresp",     32'(resp), 32'd0);
    check("post-reset hrdata",    rdata, 32'd0);
    @(posedge clk);
    #1;
    run_seq(28, 28);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ahblite_sram_slave.md
Name: ahblite_sram_slave

Overview:
AHB-Lite responder with a word-organised local memory. It sits on one slv_ port of ahblite_interconnect and is the far end of the master-issued transfers. It provides a configurable wait-state count, byte/halfword/word writes, and a two-cycle ERROR response for illegal transfers. It also serves as the reference slave model for interconnect benches.

Parameters:
HADDR_WIDTH, 32, address bus width.
HDATA_WIDTH, 32, data bus width; only 32 is supported.
MEM_DEPTH, 256, memory depth in 32-bit words; a power of 2.
WAIT_STATES, 0, number of HREADYOUT=0 cycles inserted in every OKAY data phase; range 0..15.
PROT_BASE, 'h80, byte offset where the protected region starts; used only with the optional feature.

Ports:
HCLK  in  1  clock.
HRESET  in  1  reset; synchronous, active-high.
HSEL_i  in  1  slave select from the decoder.
HTRANS_i  in  2  transfer type.
HBURST_i  in  3  burst type; ignored (every beat is handled independently).
HSIZE_i  in  3  transfer size.
HWRITE_i  in  1  1 = write, 0 = read.
HADDR_i  in  HADDR_WIDTH  byte address.
HWDATA_i  in  HDATA_WIDTH  write data.
HPROT_i  in  7  protection bits.
HMASTLOCK_i  in  1  ignored.
HREADY_i  in  1  bus-wide HREADY.
HREADYOUT_o  out  1  slave ready.
HRDATA_o  out  HDATA_WIDTH  read data.
HRESP_o  out  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Reset values: HREADYOUT_o=1, HRESP_o=0, HRDATA_o=0, FSM=IDLE, wait counter=0, address-phase registers=0. Memory contents are not reset.
- Accept condition: HSEL_i & HREADY_i & HTRANS_i[1]. On that edge, latch HADDR, HSIZE, HWRITE and HPROT.
- IDLE/BUSY transfers, or HSEL_i=0, get a zero-wait OKAY; no state change.
- Transfer is illegal when any of these holds:
  - byte offset >= MEM_DEPTH*4;
  - HSIZE > WORD;
  - misaligned: halfword with HADDR[0]=1, or word with HADDR[1:0]!=0.
- FSM states: IDLE, WAIT, LAST, ERR1, ERR2.
  - IDLE: legal accept -> WAIT if WAIT_STATES>0, else LAST. Illegal accept -> ERR1.
  - WAIT: HREADYOUT_o=0, HRESP_o=0. Counter counts up; at WAIT_STATES-1 -> LAST.
  - LAST: HREADYOUT_o=1, HRESP_o=0. Completes the data phase. A new accept in the same cycle follows the IDLE rules (back-to-back pipelining); otherwise -> IDLE.
  - ERR1: HREADYOUT_o=0, HRESP_o=1 -> ERR2.
  - ERR2: HREADYOUT_o=1, HRESP_o=1. A new accept follows the IDLE rules; otherwise -> IDLE.
- Write: HWDATA_i is sampled on the edge ending LAST and written to mem[addr>>2] under byte strobes.
  - Strobes: byte -> 1<<addr[1:0]; halfword -> 'b11<<addr[1:0]; word -> 'hF.
  - ERROR transfers never write.
- Read: HRDATA_o = mem[latched addr>>2] in LAST when the latched HWRITE=0; full word returned regardless of size. HRDATA_o=0 in all other cycles.
- Write followed immediately by a read of the same word: the read returns the new data, because the write lands at the end of the write data phase before the read data phase is presented.
- HREADY_i=0 while in IDLE: no accept; outputs hold.
- HRESET asserted mid-transfer: the FSM returns to IDLE on the next edge. Any pending write is dropped and memory is unchanged.

Optional Feature:
AHBL_SRAM_WRITE_PROTECT_EN
- Defined: a write with HPROT_i[1]=0 (unprivileged) to byte offset >= PROT_BASE is illegal and gets the two-cycle ERROR; no write. Reads are unaffected.
- Undefined: HPROT_i is ignored and PROT_BASE is unused.

Decomposition:
- Package ahblite_pkg holds:
  - HTRANS constants: IDLE, BUSY, NONSEQ, SEQ.
  - HSIZE constants: BYTE, HALFWORD, WORD.
  - HBURST constants.
  - HRESP constants: OKAY, ERROR.
  - FSM state enum.
- One sub-module: ahblite_slv_wstrb_gen (combinational; HSIZE and addr[1:0] -> 4-bit byte strobe).

Test Plan:
1. WAIT_STATES=0: NONSEQ word write 'h10 = 'hDEADBEEF, then NONSEQ word read 'h10 back-to-back -> read LAST cycle returns HRDATA='hDEADBEEF with OKAY; zero wait cycles.
2. WAIT_STATES=2: word read 'h04 -> exactly 2 cycles HREADYOUT=0, then 1 cycle HREADYOUT=1 with the data; HRESP=0 throughout.
3. Byte writes 'h11 to 'h20, 'h22 to 'h21, halfword write 'h4433 to 'h22 -> word read 'h20 returns 'h44332211.
4. Word read 'h02 (misaligned), then word write 'h400 (MEM_DEPTH=256) -> each gets ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1); memory unchanged.
5. HRESET pulsed during the WAIT state of a write -> next cycle HREADYOUT=1, HRESP=0, HRDATA=0; a subsequent read shows the old data.
6. With AHBL_SRAM_WRITE_PROTECT_EN: write 'h80 with HPROT[1]=0 -> ERROR; same write with HPROT[1]=1 -> OKAY and the data is stored.
